// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite constants, response codes and FSM state types for the memory slave.
package axi_lite_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic [0:0] {R_IDLE, R_DATA} rd_state_t;

endpackage

// File: rtl/axi_lite_mem_slave_if.sv
// AXI4-Lite bus bundle between a master (loader / fetch unit) and the memory slave.
interface axi_lite_mem_slave_if #(
  parameter int unsigned ADDR_W = 20
);
  import axi_lite_pkg::*;

  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi_mem_array.sv
// Word array with one byte-enabled write port and one registered read port.
// A read and a write to the same word on the same edge returns the old contents.
module axi_mem_array import axi_lite_pkg::*; #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [STRB_W-1:0]        wstrb_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb_i[i]) begin
          mem[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  // Only the output register is reset; contents survive reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite slave backed by an on-chip word array; independent write and read FSMs.
// Define AXI_MEM_SLVERR_EN to answer out-of-range accesses with SLVERR instead of wrapping.
module axi_lite_mem_slave #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024
) (
  input logic                 s_axi_aclk,
  input logic                 s_axi_aresetn,
  axi_lite_mem_slave_if.slave s_axi
);
  import axi_lite_pkg::*;

  localparam int unsigned IdxW  = $clog2(DEPTH);
  localparam int unsigned WordW = ADDR_W - 2;

  function automatic logic out_of_range(logic [WordW-1:0] word);
    return 32'(word) >= DEPTH;
  endfunction

  // Write channel
  wr_state_t         wr_state_q, wr_state_d;
  logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic              awready_q, awready_d, wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [WordW-1:0]  waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              aw_hs, w_hs, commit, wr_err, mem_we;

  assign aw_hs  = s_axi.awvalid & awready_q;
  assign w_hs   = s_axi.wvalid & wready_q;
  assign commit = (wr_state_q == W_IDLE) & aw_held_q & w_held_q;
`ifdef AXI_MEM_SLVERR_EN
  assign wr_err = out_of_range(waddr_q);
`else
  assign wr_err = 1'b0;
`endif
  assign mem_we = commit & ~wr_err;

  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          waddr_d   = s_axi.awaddr[ADDR_W-1:2];
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = s_axi.wdata;
          wstrb_d  = s_axi.wstrb;
        end
        if (commit) begin
          bvalid_d   = 1'b1;
          bresp_d    = wr_err ? RESP_SLVERR : RESP_OKAY;
          awready_d  = 1'b0;
          wready_d   = 1'b0;
          wr_state_d = W_RESP;
        end else begin
          awready_d = ~aw_held_d;
          wready_d  = ~w_held_d;
        end
      end
      W_RESP: begin
        if (s_axi.bready) begin
          bvalid_d   = 1'b0;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wr_state_q <= W_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
    end
  end

  // Read channel: the array is read on the AR edge, rvalid follows one edge later.
  rd_state_t   rd_state_q, rd_state_d;
  logic        arready_q, arready_d, rvalid_q, rvalid_d;
  logic        rd_pend_q, rd_pend_d, rd_err_q, rd_err_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        ar_hs, rd_oor;
  logic [DATA_W-1:0] mem_rdata;

  assign ar_hs = s_axi.arvalid & arready_q;
`ifdef AXI_MEM_SLVERR_EN
  assign rd_oor = out_of_range(s_axi.araddr[ADDR_W-1:2]);
`else
  assign rd_oor = 1'b0;
`endif

  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rd_pend_d  = rd_pend_q;
    rd_err_d   = rd_err_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      R_IDLE: begin
        if (rd_pend_q) begin
          rd_pend_d  = 1'b0;
          rvalid_d   = 1'b1;
          rresp_d    = rd_err_q ? RESP_SLVERR : RESP_OKAY;
          arready_d  = 1'b0;
          rd_state_d = R_DATA;
        end else if (ar_hs) begin
          rd_pend_d = 1'b1;
          rd_err_d  = rd_oor;
          arready_d = 1'b0;
        end else begin
          arready_d = 1'b1;
        end
      end
      R_DATA: begin
        if (s_axi.rready) begin
          rvalid_d   = 1'b0;
          arready_d  = 1'b1;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_err_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rd_pend_q  <= rd_pend_d;
      rd_err_q   <= rd_err_d;
      rresp_q    <= rresp_d;
    end
  end

  axi_mem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk_i   (s_axi_aclk),
    .rst_ni  (s_axi_aresetn),
    .we_i    (mem_we),
    .waddr_i (waddr_q[IdxW-1:0]),
    .wdata_i (wdata_q),
    .wstrb_i (wstrb_q),
    .re_i    (ar_hs),
    .raddr_i (s_axi.araddr[2 +: IdxW]),
    .rdata_o (mem_rdata)
  );

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rd_err_q ? '0 : mem_rdata;

  logic unused_bits;
  assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr, waddr_q};

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Randomized self-checking bench for axi_lite_mem_slave against a word-array reference model.
module tb_axi_lite_mem_slave;

  localparam int unsigned DEPTH = 1024;
`ifdef AXI_MEM_SLVERR_EN
  localparam bit SlvErr = 1'b1;
`else
  localparam bit SlvErr = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_lite_mem_slave_if #(.ADDR_W(20)) bus ();

  axi_lite_mem_slave #(
    .ADDR_W (20),
    .DATA_W (32),
    .DEPTH  (DEPTH)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .s_axi         (bus)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] model [DEPTH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit oor(logic [19:0] a);
    return (int'(a) / 4) >= DEPTH;
  endfunction

  function automatic int word_of(logic [19:0] a);
    return (int'(a) / 4) % DEPTH;
  endfunction

  function automatic logic [1:0] model_write(logic [19:0] a, logic [31:0] d, logic [3:0] s);
    if (SlvErr && oor(a)) return 2'b10;
    for (int i = 0; i < 4; i++) begin
      if (s[i]) model[word_of(a)][8*i +: 8] = d[8*i +: 8];
    end
    return 2'b00;
  endfunction

  function automatic logic [33:0] model_read(logic [19:0] a);
    if (SlvErr && oor(a)) return {2'b10, 32'h0};
    return {2'b00, model[word_of(a)]};
  endfunction

  task automatic do_write(input logic [19:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    bit aw_done = 0;
    bit w_done = 0;
    bit awf, wf;
    int c = 0;
    logic [1:0] exp_resp;
    while (!(aw_done && w_done) && c < 64) begin
      @(negedge clk);
      bus.awaddr  = addr;
      bus.wdata   = data;
      bus.wstrb   = strb;
      bus.awvalid = !aw_done && (c >= aw_dly);
      bus.wvalid  = !w_done && (c >= w_dly);
      if (w_done && !aw_done) check("w_closed", bus.wready, 0);
      if (aw_done && !w_done) check("aw_closed", bus.awready, 0);
      awf = bus.awvalid && bus.awready;
      wf  = bus.wvalid && bus.wready;
      @(posedge clk);
      if (awf) aw_done = 1;
      if (wf) w_done = 1;
      c++;
    end
    check("wr_hs_done", {aw_done, w_done}, 2'b11);
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    check("b_early", {bus.bvalid, bus.awready, bus.wready}, 3'b000);
    exp_resp = model_write(addr, data, strb);
    @(posedge clk);
    @(negedge clk);
    check("b_valid", {bus.bvalid, bus.bresp}, {1'b1, exp_resp});
    for (int i = 0; i < b_dly; i++) begin
      bus.bready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("b_hold", {bus.bvalid, bus.bresp, bus.awready, bus.wready}, {1'b1, exp_resp, 2'b00});
    end
    bus.bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.bready = 1'b0;
    check("b_done", {bus.bvalid, bus.awready, bus.wready}, 3'b011);
  endtask

  task automatic do_read(input logic [19:0] addr, input int r_dly,
                         input logic [31:0] exp_data, input logic [1:0] exp_resp);
    bit done = 0;
    bit arf;
    int c = 0;
    while (!done && c < 64) begin
      @(negedge clk);
      bus.araddr  = addr;
      bus.arvalid = 1'b1;
      arf = bus.arready;
      @(posedge clk);
      if (arf) done = 1;
      c++;
    end
    check("rd_hs_done", done, 1);
    @(negedge clk);
    bus.arvalid = 1'b0;
    check("r_early", {bus.rvalid, bus.arready}, 2'b00);
    @(posedge clk);
    @(negedge clk);
    check("r_valid", {bus.rvalid, bus.rresp, bus.rdata}, {1'b1, exp_resp, exp_data});
    for (int i = 0; i < r_dly; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("r_hold", {bus.rvalid, bus.arready, bus.rresp, bus.rdata},
            {1'b1, 1'b0, exp_resp, exp_data});
    end
    bus.rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rready = 1'b0;
    check("r_done", {bus.rvalid, bus.arready}, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [33:0] rr;
    logic [31:0] old_val;
    logic [19:0] a;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    #12;
    check("reset_outs", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid,
                         bus.bresp, bus.rresp, bus.rdata}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_pre", {bus.awready, bus.wready, bus.arready}, 3'b000);
    @(posedge clk);
    @(negedge clk);
    check("ready_post", {bus.awready, bus.wready, bus.arready}, 3'b111);

    do_write(20'h00000, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    do_read(20'h00000, 0, 32'hDEADBEEF, 2'b00);

    do_write(20'h00004, 32'h12345678, 4'hF, 3, 0, 0);
    do_read(20'h00004, 0, 32'h12345678, 2'b00);

    do_write(20'h00008, 32'hFFFFFFFF, 4'hF, 0, 2, 0);
    do_write(20'h00008, 32'h000000AA, 4'b0001, 0, 0, 0);
    do_read(20'h00008, 0, 32'hFFFFFFAA, 2'b00);
    do_write(20'h00008, 32'h11223344, 4'b0000, 1, 1, 0);
    do_read(20'h00008, 0, 32'hFFFFFFAA, 2'b00);

    do_write(20'h0000C, 32'hA5A55A5A, 4'hF, 0, 0, 5);
    do_read(20'h0000C, 5, 32'hA5A55A5A, 2'b00);

    // Loader image followed by sequential fetches.
    for (int i = 0; i < 88; i++) do_write(20'(i * 4), $urandom, 4'hF, 0, 0, 0);
    do_write(20'h00160, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    for (int i = 0; i <= 88; i++) begin
      rr = model_read(20'(i * 4));
      do_read(20'(i * 4), 0, rr[31:0], rr[33:32]);
    end

    do_write(20'h01000, 32'hCAFEF00D, 4'hF, 0, 0, 0);
    rr = model_read(20'h01000);
    do_read(20'h01000, 0, rr[31:0], rr[33:32]);
    do_read(20'h00000, 0, model[0], 2'b00);

    // Commit and AR on the same edge to the same word: read sees the old word.
    old_val = model[16];
    fork
      do_write(20'h00040, ~old_val, 4'hF, 0, 0, 0);
      begin
        @(negedge clk);
        do_read(20'h00040, 0, old_val, 2'b00);
      end
    join
    do_read(20'h00040, 0, ~old_val, 2'b00);

    for (int n = 0; n < 80; n++) begin
      a = 20'($urandom_range(0, 88) * 4);
      if ($urandom_range(0, 7) == 0) a = a + 20'($urandom_range(1, 3) * 4096);
      if ($urandom_range(0, 1) == 0) begin
        do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3));
      end else begin
        rr = model_read(a);
        do_read(a, $urandom_range(0, 3), rr[31:0], rr[33:32]);
      end
    end

    // Reset between handshake and commit drops the write.
    @(negedge clk);
    bus.awaddr  = 20'h00014;
    bus.wdata   = ~model[5];
    bus.wstrb   = 4'hF;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    #1 check("rst_clear", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_ready", {bus.awready, bus.wready, bus.arready, bus.bvalid}, 4'b1110);
    do_read(20'h00014, 0, model[5], 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
